// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin registered multiplexer.
// The packet-lock FSM state type is only used when RR_MUX_LOCK_EN is defined.
package rr_mux_pkg;

    // Widest channel count the one-hot decoder supports.
    localparam int RR_MAX_N = 32;

    typedef enum logic {
        SCAN   = 1'b0,
        LOCKED = 1'b1
    } rr_state_e;

    function automatic int unsigned onehot_to_idx(input logic [RR_MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < RR_MAX_N; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping around to channel 0.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int N   = 4,
    localparam int CHW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [CHW-1:0] ptr,
    output logic [N-1:0]   gnt_oh,
    output logic [CHW-1:0] gnt_idx,
    output logic           gnt_any
);

    logic                found_s;
    logic [RR_MAX_N-1:0] oh_ext_s;

    // Two passes: upper segment [ptr, N-1] has priority over the wrapped segment [0, ptr-1].
    always_comb begin
        gnt_oh  = '0;
        found_s = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found_s && req[j] && (j >= int'(ptr))) begin
                gnt_oh[j] = 1'b1;
                found_s   = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found_s && req[j] && (j < int'(ptr))) begin
                gnt_oh[j] = 1'b1;
                found_s   = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Index of the granted channel, derived from the one-hot grant.
    always_comb begin
        oh_ext_s        = '0;
        oh_ext_s[N-1:0] = gnt_oh;
        gnt_idx         = CHW'(onehot_to_idx(oh_ext_s));
        gnt_any         = |req;
    end

endmodule

// File: rtl/rr_mux.sv
// N-channel, W-bit round-robin multiplexer with one registered output stage.
// Define RR_MUX_LOCK_EN to add the in_last port and hold the grant for a whole packet.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter  int N   = 4,
    parameter  int W   = 8,
    localparam int CHW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
    input  logic [N-1:0]   in_last,
`endif
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [CHW-1:0] out_chan,
    input  logic           out_ready
);

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [CHW-1:0] out_chan_q, out_chan_d;
    logic [CHW-1:0] ptr_q, ptr_d;

    logic           load_s;
    logic           xfer_s;
    logic           adv_s;
    logic [N-1:0]   req_s;
    logic [N-1:0]   gnt_oh_s;
    logic [CHW-1:0] gnt_idx_s;
    logic           gnt_any_s;
    logic [W-1:0]   sel_data_s;
    logic [CHW-1:0] ptr_next_s;

`ifdef RR_MUX_LOCK_EN
    rr_state_e      state_q, state_d;
    logic [CHW-1:0] lock_chan_q, lock_chan_d;
    logic [N-1:0]   lock_mask_s;
    logic           last_s;

    // While locked only the owning channel may compete for the grant.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lock_mask_s[i] = (CHW'(i) == lock_chan_q);
        end
        if (state_q == LOCKED) begin
            req_s = in_valid & lock_mask_s;
        end else begin
            req_s = in_valid;
        end
    end
`else
    // Every beat is arbitrated on its own.
    always_comb begin
        req_s = in_valid;
    end
`endif

    rr_arbiter #(.N(N)) u_arb (
        .req     (req_s),
        .ptr     (ptr_q),
        .gnt_oh  (gnt_oh_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Handshake: the output register can take a beat when empty or draining; nothing is accepted under reset.
    always_comb begin
        load_s   = ~out_valid_q | out_ready;
        xfer_s   = load_s & gnt_any_s & ~rst;
        in_ready = xfer_s ? gnt_oh_s : '0;
        sel_data_s = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_oh_s[i]) begin
                sel_data_s = in_data[i*W +: W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        if (gnt_idx_s == CHW'(N - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = gnt_idx_s + CHW'(1);
        end
    end

`ifdef RR_MUX_LOCK_EN
    // Packet-lock FSM: a non-last beat pins the grant; the last beat releases it and advances ptr.
    always_comb begin
        state_d     = state_q;
        lock_chan_d = lock_chan_q;
        adv_s       = 1'b0;
        last_s      = |(in_last & gnt_oh_s);
        case (state_q)
            SCAN: begin
                if (xfer_s && !last_s) begin
                    state_d     = LOCKED;
                    lock_chan_d = gnt_idx_s;
                end else begin
                    adv_s = xfer_s;
                end
            end
            LOCKED: begin
                if (xfer_s && last_s) begin
                    state_d = SCAN;
                    adv_s   = 1'b1;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            lock_chan_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_chan_q <= lock_chan_d;
        end
    end
`else
    // Without packet lock every transfer advances the pointer.
    always_comb begin
        adv_s = xfer_s;
    end
`endif

    // Output register and pointer next-state; a drain with nothing to load empties the register.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_chan_d  = gnt_idx_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (adv_s) begin
            ptr_d = ptr_next_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Output stage and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux (N=4, W=8): directed vectors plus a per-cycle model comparison.
// Packet-lock scenario runs only when RR_MUX_LOCK_EN is defined.
module tb_rr_mux;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int CHW = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CHW-1:0] out_chan;
    logic           out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    rr_mux #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer pointer, register contents, lock owner.
    int         m_ptr;
    bit         m_v;
    logic [7:0] m_d;
    int         m_c;
    bit         m_locked;
    int         m_lch;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] eff_valid();
        logic [N-1:0] v;
        v = in_valid;
`ifdef RR_MUX_LOCK_EN
        if (m_locked) v = in_valid & (4'b0001 << m_lch);
`endif
        return v;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        logic [N-1:0] r;
        r = '0;
        g = pick(eff_valid(), m_ptr);
        if (!rst && (!m_v || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0; m_v = 0; m_d = 8'h00; m_c = 0; m_locked = 0; m_lch = 0;
        end else begin
            int g;
            g = pick(eff_valid(), m_ptr);
            if ((!m_v || out_ready) && g >= 0) begin
                m_v = 1; m_d = in_data[g*W +: W]; m_c = g;
`ifdef RR_MUX_LOCK_EN
                if (!m_locked && !in_last[g]) begin
                    m_locked = 1; m_lch = g;
                end else if (m_locked && in_last[g]) begin
                    m_locked = 0; m_ptr = (g + 1) % N;
                end else if (!m_locked) begin
                    m_ptr = (g + 1) % N;
                end
`else
                m_ptr = (g + 1) % N;
`endif
            end else if (out_ready) begin
                m_v = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_v});
        if (m_v) begin
            check("cyc_out_data", {24'd0, out_data}, {24'd0, m_d});
            check("cyc_out_chan", {30'd0, out_chan}, m_c);
        end
        check("cyc_in_ready", {28'd0, in_ready}, {28'd0, exp_ready()});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'b0000; in_data = 32'h0000_0000; in_last = 4'b1111; out_ready = 1'b0;
        cyc(); cyc();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_chan", {30'd0, out_chan}, 32'd0);
        rst = 1'b0;

        // All channels valid: strict rotation with no gaps.
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("rot_valid", {31'd0, out_valid}, 32'd1);
            check("rot_chan", {30'd0, out_chan}, i % 4);
            check("rot_data", {24'd0, out_data}, 32'hA0 + (i % 4));
            check("rot_ready", {28'd0, in_ready}, 32'd1 << ((i + 1) % 4));
        end

        // Nothing valid while draining: register empties, pointer stays.
        in_valid = 4'b0000;
        cyc();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_mptr", m_ptr, 32'd1);
        check("drain_ptr", {30'd0, dut.ptr_q}, 32'd1);

        // Backpressure: single channel 2, consumer stalls three cycles.
        in_data = {8'hA3, 8'h5C, 8'hA1, 8'hA0}; in_valid = 4'b0100; out_ready = 1'b0;
        #1;
        check("bp_ready_first", {28'd0, in_ready}, 32'h4);
        cyc();
        in_data = {8'hA3, 8'h5D, 8'hA1, 8'hA0};
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_data", {24'd0, out_data}, 32'h5C);
            check("bp_hold_chan", {30'd0, out_chan}, 32'd2);
            check("bp_hold_ready", {28'd0, in_ready}, 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {28'd0, in_ready}, 32'h4);
        cyc();
        check("bp_next_data", {24'd0, out_data}, 32'h5D);
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 4'b0000;
        cyc();
        check("bp_ptr", {30'd0, dut.ptr_q}, 32'd3);

        // Wrap from ptr=3: channel 0 then channel 2.
        in_data = {8'hA3, 8'h22, 8'hA1, 8'h11}; in_valid = 4'b0101;
        cyc();
        check("wrap_chan0", {30'd0, out_chan}, 32'd0);
        check("wrap_data0", {24'd0, out_data}, 32'h11);
        check("wrap_ptr0", {30'd0, dut.ptr_q}, 32'd1);
        check("wrap_mptr0", m_ptr, 32'd1);
        cyc();
        check("wrap_chan2", {30'd0, out_chan}, 32'd2);
        check("wrap_data2", {24'd0, out_data}, 32'h22);
        check("wrap_ptr2", {30'd0, dut.ptr_q}, 32'd3);
        in_valid = 4'b0000;
        cyc();

        // Asynchronous reset with a held beat.
        in_valid = 4'b0001; out_ready = 1'b0;
        cyc();
        check("arst_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_data", {24'd0, out_data}, 32'd0);
        check("arst_chan", {30'd0, out_chan}, 32'd0);
        check("arst_ready", {28'd0, in_ready}, 32'd0);
        check("arst_ptr", {30'd0, dut.ptr_q}, 32'd0);
        cyc();
        rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
        cyc();

`ifdef RR_MUX_LOCK_EN
        // Packet lock: ch1 sends 3 beats while ch0/ch2 also request.
        in_data = {8'hA3, 8'hC2, 8'hB1, 8'hC0}; in_valid = 4'b0001; in_last = 4'b1111;
        cyc();
        check("lk_pre_chan", {30'd0, out_chan}, 32'd0);
        in_valid = 4'b0111;
        for (int b = 0; b < 3; b++) begin
            in_last = (b == 2) ? 4'b1111 : 4'b1101;
            in_data[15:8] = 8'hB1 + b[7:0];
            cyc();
            check("lk_chan1", {30'd0, out_chan}, 32'd1);
            check("lk_data1", {24'd0, out_data}, 32'hB1 + b);
        end
        in_valid = 4'b0101; in_last = 4'b1111;
        cyc();
        check("lk_chan2", {30'd0, out_chan}, 32'd2);
        cyc();
        check("lk_chan0", {30'd0, out_chan}, 32'd0);
        in_valid = 4'b0000;
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
